mac_more_ctrl: RTL and testbench
================================

MAC_MORE_CTRL -- requirements
Module: mac_more_ctrl

Interface
REQ-001 SHALL have parameter IC0, default 2, array height (weight rows loaded per job).
REQ-002 SHALL have parameter OC0, default 2, array width (informational; no width dependence in control).
REQ-003 SHALL have parameter ARRAY_LAT, default IC0+OC0, cycles from ifmap enqueue to the matching accum_out enqueue; legal range >= 1.
REQ-004 SHALL have parameter CNT_W, default 16, width of job-length counters.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-008 SHALL have port num_ifmap  input  CNT_W  ifmap vectors in the job; latched when start is accepted.
REQ-009 SHALL have port w_valid  input  1  weight source holds a valid row this cycle.
REQ-010 SHALL have port x_valid  input  1  ifmap and accum_in sources hold valid vectors this cycle.
REQ-011 SHALL have port en  output  1  array enable.
REQ-012 SHALL have port en_weight00  output  1  weight-latch enable for cell (0,0).
REQ-013 SHALL have ports weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq, accum_out_fifo_enq  output  1 each  FIFO enqueue strobes.
REQ-014 SHALL have ports busy, done  output  1 each  job active; one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-016 IDLE: start=1 and num_ifmap!=0 -> LOAD_W, num latched; start=1 and num_ifmap==0 -> DONE; otherwise stay.
REQ-017 LOAD_W: weight_fifo_enq = w_valid; w_cnt increments per enqueue; -> STREAM on the cycle the IC0-th row is enqueued.
REQ-018 en_weight00 SHALL be 1 only in the cycle the first weight row of a job is enqueued (w_cnt==0 and w_valid).
REQ-019 STREAM: ifmap_fifo_enq = accum_in_fifo_enq = x_valid; x_cnt increments per enqueue; -> DRAIN on the cycle the num-th vector is enqueued.
REQ-020 Enqueue strobes SHALL be combinational on state and valid inputs; no enqueue while the relevant valid is 0 (stall, counters hold).
REQ-021 accum_out_fifo_enq SHALL assert exactly ARRAY_LAT cycles after each ifmap enqueue (delay-line of ARRAY_LAT bits), preserving stall gaps.
REQ-022 out_cnt SHALL count accum_out enqueues; DRAIN -> DONE on the cycle out_cnt reaches num (final accum_out enqueue cycle).
REQ-023 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-024 en SHALL be 1 in LOAD_W, STREAM, DRAIN; 0 in IDLE and DONE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start SHALL be ignored outside IDLE; num_ifmap changes after acceptance SHALL have no effect.
REQ-027 Counters SHALL be CNT_W bits; num_ifmap = 2^CNT_W-1 SHALL complete without wrap.
REQ-028 Delay line and out_cnt SHALL be cleared on entry to IDLE so no strobe leaks into the next job.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, all counters and delay-line 0, and every output 0, regardless of current state.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification (IC0=OC0=2, ARRAY_LAT=4, cycle 0 = start accepted)
REQ-031 num=4, w_valid=x_valid=1 -> weight_fifo_enq cycles 1-2, en_weight00 cycle 1 only, ifmap/accum_in enq cycles 3-6, accum_out enq cycles 7-10, done cycle 11, busy 0 from cycle 12.
REQ-032 As REQ-031 but x_valid=0 in cycles 4-5 -> ifmap enq cycles 3,6,7,8; accum_out enq cycles 7,10,11,12; done cycle 13.
REQ-033 w_valid=0 in cycle 1 -> en_weight00 and first weight enq in cycle 2, second in cycle 3, first ifmap enq cycle 4.
REQ-034 num_ifmap=0 with start -> done cycle 1, no enqueue strobe and en=0 throughout.
REQ-035 start pulsed during STREAM -> ignored, job of REQ-031 timing unchanged, single done.
REQ-036 rst_n=0 at cycle 5 of REQ-031 -> all outputs 0 that cycle with no pending accum_out strobes; new start after release replays REQ-031 timing.

Source files
------------

// File: rtl/mac_more_ctrl.sv
// mac_more_ctrl: job sequencer for a systolic MAC array.
// It loads IC0 weight rows, streams num ifmap vectors, then drains the matching accum_out vectors.
module mac_more_ctrl #(
   parameter int IC0       = 2,
   parameter int OC0       = 2,
   parameter int ARRAY_LAT = IC0 + OC0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_ifmap,
   input  logic             w_valid,
   input  logic             x_valid,
   output logic             en,
   output logic             en_weight00,
   output logic             weight_fifo_enq,
   output logic             ifmap_fifo_enq,
   output logic             accum_in_fifo_enq,
   output logic             accum_out_fifo_enq,
   output logic             busy,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     num, w_cnt, x_cnt, out_cnt;
   logic [ARRAY_LAT-1:0] dl;
   logic [ARRAY_LAT:0]   dl_n;
   logic                 w_last, x_last, out_last;

   if (OC0 < 1 || ARRAY_LAT < 1 || IC0 < 1) begin : g_bad_param
      $error("mac_more_ctrl: IC0, OC0 and ARRAY_LAT must be >= 1");
   end

   assign w_last   = w_cnt == CNT_W'(IC0 - 1);
   assign x_last   = x_cnt == num - CNT_W'(1);
   assign out_last = out_cnt == num - CNT_W'(1);
   // Shift-by-one built one bit wider so ARRAY_LAT=1 needs no special case
   assign dl_n     = {dl, ifmap_fifo_enq};

   always_comb begin
      busy               = state != IDLE;
      en                 = state == LOAD_W || state == STREAM || state == DRAIN;
      done               = state == DONE;
      weight_fifo_enq    = state == LOAD_W && w_valid;
      en_weight00        = weight_fifo_enq && w_cnt == '0;
      ifmap_fifo_enq     = state == STREAM && x_valid;
      accum_in_fifo_enq  = ifmap_fifo_enq;
      accum_out_fifo_enq = dl[ARRAY_LAT-1];
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? (num_ifmap != '0 ? LOAD_W : DONE) : IDLE;
         LOAD_W:  state_n = weight_fifo_enq && w_last ? STREAM : LOAD_W;
         STREAM:  state_n = ifmap_fifo_enq && x_last ? DRAIN : STREAM;
         DRAIN:   state_n = accum_out_fifo_enq && out_last ? DONE : DRAIN;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         num     <= '0;
         w_cnt   <= '0;
         x_cnt   <= '0;
         out_cnt <= '0;
         dl      <= '0;
      end else begin
         state <= state_n;
         dl    <= dl_n[ARRAY_LAT-1:0];
         if (state == IDLE && start) num <= num_ifmap;
         if (weight_fifo_enq) w_cnt <= w_last ? '0 : w_cnt + CNT_W'(1);
         if (ifmap_fifo_enq) x_cnt <= x_last ? '0 : x_cnt + CNT_W'(1);
         if (accum_out_fifo_enq) out_cnt <= out_cnt + CNT_W'(1);
         // Leaving DONE for IDLE: wipe per-job state so nothing leaks forward
         if (state == DONE) begin
            w_cnt   <= '0;
            x_cnt   <= '0;
            out_cnt <= '0;
            dl      <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mac_more_ctrl.sv
// tb_mac_more_ctrl: directed per-cycle checks of mac_more_ctrl job timing (IC0=OC0=2, ARRAY_LAT=4).
module tb_mac_more_ctrl;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_ifmap = '0;
   logic             w_valid = 1'b0;
   logic             x_valid = 1'b0;
   logic             en, en_weight00, weight_fifo_enq, ifmap_fifo_enq;
   logic             accum_in_fifo_enq, accum_out_fifo_enq, busy, done;
   int               tests = 0;
   int               fails = 0;

   mac_more_ctrl #(.IC0(2), .OC0(2), .ARRAY_LAT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_ifmap(num_ifmap),
      .w_valid(w_valid), .x_valid(x_valid), .en(en), .en_weight00(en_weight00),
      .weight_fifo_enq(weight_fifo_enq), .ifmap_fifo_enq(ifmap_fifo_enq),
      .accum_in_fifo_enq(accum_in_fifo_enq), .accum_out_fifo_enq(accum_out_fifo_enq),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {en, en_weight00, weight_fifo_enq, ifmap_fifo_enq,
              accum_in_fifo_enq, accum_out_fifo_enq, busy, done};
   endfunction

   task automatic check(input string tag, input int c, input logic [7:0] exp);
      logic [7:0] obs;
      obs = outs();
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cycle %0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   // Entered just after a rising edge with the DUT idle; cycle 0 is the start-accept cycle.
   task automatic run_job(input string tag, input logic [CNT_W-1:0] num,
                          input logic [63:0] xstall, input logic [63:0] wstall,
                          input logic [63:0] start_mask, input logic [63:0] w_m,
                          input logic [63:0] ew_m, input logic [63:0] if_m,
                          input logic [63:0] ao_m, input int done_c, input int ncyc);
      logic [7:0] exp;
      for (int c = 0; c < ncyc; c++) begin
         #2;
         start     = (c == 0) || start_mask[c];
         num_ifmap = (c == 0) ? num : CNT_W'($urandom);
         w_valid   = !wstall[c];
         x_valid   = !xstall[c];
         #1;
         exp = {c >= 1 && c < done_c, ew_m[c], w_m[c], if_m[c], if_m[c], ao_m[c],
                c >= 1 && c <= done_c, c == done_c};
         check(tag, c, exp);
         @(posedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      #3;
      check("reset_outputs", 0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      run_job("basic", 16'd4, 64'h0, 64'h0, 64'h0, 64'h6, 64'h2, 64'h78, 64'h780, 11, 13);
      run_job("x_stall", 16'd4, 64'h30, 64'h0, 64'h0, 64'h6, 64'h2, 64'h1C8, 64'h1C80, 13, 15);
      run_job("w_stall", 16'd4, 64'h0, 64'h2, 64'h0, 64'hC, 64'h4, 64'hF0, 64'hF00, 12, 14);
      run_job("num_zero", 16'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3);
      run_job("start_ignored", 16'd4, 64'h0, 64'h0, 64'h830, 64'h6, 64'h2, 64'h78, 64'h780, 11, 13);
      run_job("single_vec", 16'd1, 64'h0, 64'h0, 64'h0, 64'h6, 64'h2, 64'h8, 64'h80, 8, 10);
      run_job("pre_reset", 16'd4, 64'h0, 64'h0, 64'h0, 64'h6, 64'h2, 64'h78, 64'h780, 11, 5);
      #2;
      w_valid = 1'b1;
      x_valid = 1'b1;
      rst_n   = 1'b0;
      #1;
      check("async_reset", 5, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("held_reset", 6, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      run_job("after_reset", 16'd4, 64'h0, 64'h0, 64'h0, 64'h6, 64'h2, 64'h78, 64'h780, 11, 13);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
